// File: rtl/uc_secuenciador_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the
// instruction memory (slave).
`timescale 1ns/1ps
interface uc_secuenciador_if;
  logic       imem_req;
  logic       imem_ack;
  logic [5:0] instr_op;

  modport master (output imem_req, input imem_ack, input instr_op);
  modport slave  (input imem_req, output imem_ack, output instr_op);
endinterface

// File: rtl/uc_secuenciador.sv
// Multi-cycle control-unit sequencer: FETCH/DECODE/EXEC per instruction, with
// fetch timeout, absorbing HALT/ERROR states and a retired-instruction counter.
`timescale 1ns/1ps
module uc_secuenciador #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  uc_secuenciador_if.master        imem,
  input  logic                     start,
  input  logic                     z,
  output logic                     pc_load,
  output logic                     s_inc,
  output logic                     we3,
  output logic                     wez,
  output logic                     s_datos,
  output logic [2:0]               op_alu,
  output logic                     busy,
  output logic                     halted,
  output logic                     err,
  output logic [15:0]              icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [5:0]  r_ir, w_ir_next;
  logic [7:0]  r_wait, w_wait_next;
  logic [15:0] r_icount, w_icount_next;
  logic        w_is_halt;

  function automatic logic jump_taken(input logic [1:0] cond, input logic zf);
    logic taken;
    case (cond)
      2'b00:   taken = 1'b1;
      2'b01:   taken = zf;
      2'b10:   taken = ~zf;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign w_is_halt = (r_ir[5:4] == 2'b11) && (r_ir[1:0] == 2'b11);
  assign icount    = r_icount;

  // State, instruction register, wait counter and retired counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ir     <= 6'd0;
      r_wait   <= 8'd0;
      r_icount <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_ir     <= w_ir_next;
      r_wait   <= w_wait_next;
      r_icount <= w_icount_next;
    end
  end

  // Next-state logic; HALT and ERROR hold until reset.
  always_comb begin
    w_next        = r_state;
    w_ir_next     = r_ir;
    w_wait_next   = r_wait;
    w_icount_next = r_icount;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next      = S_FETCH;
          w_wait_next = 8'd0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          w_ir_next = imem.instr_op;
          w_next    = S_DECODE;
        end else if (r_wait == TIMEOUT_LAST) begin
          w_next = S_ERROR;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next        = S_FETCH;
          w_wait_next   = 8'd0;
          w_icount_next = r_icount + 16'd1;
        end
      end
      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  // Control pulses decoded from the registered state; z is looked at in EXEC.
  always_comb begin
    imem.imem_req = 1'b0;
    pc_load       = 1'b0;
    s_inc         = 1'b0;
    we3           = 1'b0;
    wez           = 1'b0;
    s_datos       = 1'b0;
    op_alu        = 3'd0;
    busy          = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        busy          = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        case (r_ir[5:4])
          2'b00: pc_load = 1'b1;
          2'b01: begin
            we3     = 1'b1;
            wez     = 1'b1;
            pc_load = 1'b1;
            op_alu  = r_ir[2:0];
          end
          2'b10: begin
            we3     = 1'b1;
            s_datos = 1'b1;
            pc_load = 1'b1;
          end
          default: begin
            if (!w_is_halt) begin
              pc_load = 1'b1;
              s_inc   = jump_taken(r_ir[1:0], z);
            end else begin
              pc_load = 1'b0;
            end
          end
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: err    = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Self-checking bench for uc_secuenciador: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
`timescale 1ns/1ps
module tb_uc_secuenciador;
  localparam int TIMEOUT = 15;
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_HALT = 4, PH_ERR = 5;

  logic        clk, reset, start, z;
  logic        pc_load, s_inc, we3, wez, s_datos, busy, halted, err;
  logic [2:0]  op_alu;
  logic [15:0] icount;
  logic        preset_req;
  logic [5:0]  rop;
  int          n_checks, n_fail, stuck, n_req;
  int          m_ph, m_ir, m_wait, m_cnt;

  uc_secuenciador_if imem ();

  uc_secuenciador #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .imem(imem), .start(start), .z(z),
    .pc_load(pc_load), .s_inc(s_inc), .we3(we3), .wez(wez), .s_datos(s_datos),
    .op_alu(op_alu), .busy(busy), .halted(halted), .err(err), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: where the current instruction is, what was fetched, how many retired.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph <= PH_IDLE; m_ir <= 0; m_wait <= 0; m_cnt <= 0;
    end else if (preset_req) begin
      m_cnt <= 65534;
    end else begin
      case (m_ph)
        PH_IDLE:   if (start) begin m_ph <= PH_FETCH; m_wait <= 0; end
        PH_FETCH:  if (imem.imem_ack) begin m_ir <= int'(imem.instr_op); m_ph <= PH_DECODE; end
                   else if (m_wait + 1 >= TIMEOUT) m_ph <= PH_ERR;
                   else m_wait <= m_wait + 1;
        PH_DECODE: m_ph <= PH_EXEC;
        PH_EXEC:   if (m_ir / 16 == 3 && m_ir % 4 == 3) m_ph <= PH_HALT;
                   else begin m_cnt <= (m_cnt + 1) % 65536; m_ph <= PH_FETCH; m_wait <= 0; end
        default: ;
      endcase
    end
  end

  function automatic logic [11:0] expected_ctrl(input int ph, input int ir, input logic zf);
    int cls, sub;
    logic req, pl, si, w3, wz, sd, bz, hl, er;
    logic [2:0] alu;
    cls = ir / 16; sub = ir % 4;
    {pl, si, w3, wz, sd} = 5'd0;
    alu = 3'd0;
    req = (ph == PH_FETCH);
    bz  = (ph == PH_FETCH) || (ph == PH_DECODE) || (ph == PH_EXEC);
    hl  = (ph == PH_HALT);
    er  = (ph == PH_ERR);
    if (ph == PH_EXEC) begin
      if (cls == 0) pl = 1'b1;
      else if (cls == 1) begin w3 = 1'b1; wz = 1'b1; pl = 1'b1; alu = 3'(ir % 8); end
      else if (cls == 2) begin w3 = 1'b1; sd = 1'b1; pl = 1'b1; end
      else if (sub != 3) begin
        pl = 1'b1;
        si = (sub == 0) || (sub == 1 && zf) || (sub == 2 && !zf);
      end
    end
    return {req, pl, si, w3, wz, sd, alu, bz, hl, er};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic compare_loop();
    logic [11:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      exp_v = expected_ctrl(m_ph, m_ir, z);
      got_v = {imem.imem_req, pc_load, s_inc, we3, wez, s_datos, op_alu, busy, halted, err};
      check("model_ctrl", 32'(got_v), 32'(exp_v));
      if (!preset_req) check("model_icount", 32'(icount), 32'(m_cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; stuck = 0; n_req = 0;
    reset = 1'b0; start = 1'b0; z = 1'b0; preset_req = 1'b0;
    imem.imem_ack = 1'b0; imem.instr_op = 6'd0;
    fork compare_loop(); join_none

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_outputs", 32'({imem.imem_req, pc_load, we3, busy, halted, err}), 32'd0);
    check("rst_icount", 32'(icount), 32'd0);
    tick(); reset = 1'b1;
    tick();
    @(negedge clk);
    check("idle_hold", 32'(busy), 32'd0);

    // ALU op 010011, ack in first FETCH cycle
    tick(); start = 1'b1;
    tick(); start = 1'b0; imem.imem_ack = 1'b1; imem.instr_op = 6'b010011;
    @(negedge clk);
    check("alu_c1_req", 32'({imem.imem_req, we3, pc_load}), 32'b100);
    tick(); imem.imem_ack = 1'b0;
    @(negedge clk);
    check("alu_c2_decode", 32'({busy, imem.imem_req, we3, wez, pc_load}), 32'b10000);
    tick();
    @(negedge clk);
    check("alu_c3_pulses", 32'({we3, wez, pc_load, s_inc, s_datos, op_alu}), 32'b11100011);
    check("alu_c3_icount", 32'(icount), 32'd0);

    // JZ taken (z=1) then not taken (z=0)
    tick(); imem.imem_ack = 1'b1; imem.instr_op = 6'b110001; z = 1'b1;
    @(negedge clk);
    check("alu_c4_icount", 32'(icount), 32'd1);
    check("alu_c4_quiet", 32'({we3, wez, pc_load}), 32'd0);
    tick(); imem.imem_ack = 1'b0;
    tick();
    @(negedge clk);
    check("jz_taken", 32'({pc_load, s_inc, we3}), 32'b110);
    tick(); imem.imem_ack = 1'b1; z = 1'b0;
    @(negedge clk);
    check("jz1_icount", 32'(icount), 32'd2);
    tick(); imem.imem_ack = 1'b0;
    tick();
    @(negedge clk);
    check("jz_not_taken", 32'({pc_load, s_inc}), 32'b10);

    // HALT: no pulses, then absorbing
    tick(); imem.imem_ack = 1'b1; imem.instr_op = 6'b110011;
    @(negedge clk);
    check("jz2_icount", 32'(icount), 32'd3);
    tick(); imem.imem_ack = 1'b0;
    tick();
    @(negedge clk);
    check("halt_exec_quiet", 32'({pc_load, s_inc, we3, wez, s_datos, busy}), 32'b000001);
    tick();
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom); imem.imem_ack = 1'($urandom);
      @(negedge clk);
      check("halt_hold", 32'({halted, busy, imem.imem_req}), 32'b100);
      check("halt_icount", 32'(icount), 32'd3);
      tick();
    end
    start = 1'b0; imem.imem_ack = 1'b0;

    // icount wrap: preset to FFFE in IDLE, then two NOPs
    do_reset();
    preset_req = 1'b1;
    force dut.r_icount = 16'hFFFE;
    tick();
    release dut.r_icount;
    preset_req = 1'b0;
    @(negedge clk);
    check("preset_icount", 32'(icount), 32'h0000FFFE);
    tick(); start = 1'b1;
    tick(); start = 1'b0; imem.imem_ack = 1'b1; imem.instr_op = 6'b000000;
    repeat (3) tick();
    @(negedge clk);
    check("wrap_ffff", 32'(icount), 32'h0000FFFF);
    repeat (3) tick();
    @(negedge clk);
    check("wrap_zero", 32'(icount), 32'd0);
    imem.imem_ack = 1'b0;

    // Fetch timeout: ack held low
    do_reset();
    start = 1'b1;
    tick(); start = 1'b0;
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err) break;
      if (imem.imem_req) n_req++;
      tick();
    end
    check("timeout_req_cycles", 32'(n_req), 32'd15);
    check("timeout_err", 32'({err, busy, imem.imem_req}), 32'b100);
    tick(); imem.imem_ack = 1'b1; start = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("err_absorbing", 32'({err, busy, imem.imem_req}), 32'b100);
    imem.imem_ack = 1'b0; start = 1'b0;

    // Reset asserted mid-EXEC (load immediate)
    do_reset();
    imem.imem_ack = 1'b1; imem.instr_op = 6'b100101; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    #1;
    check("midexec_pre", 32'({we3, s_datos, pc_load}), 32'b111);
    #1;
    reset = 1'b0;
    #1;
    check("midexec_outputs", 32'({we3, s_datos, pc_load, busy, imem.imem_req}), 32'd0);
    check("midexec_icount", 32'(icount), 32'd0);
    tick(); tick();
    imem.imem_ack = 1'b0;
    reset = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rop = 6'($urandom);
      if (rop[5:4] == 2'b11 && rop[1:0] == 2'b11 && $urandom_range(0, 7) != 0) rop[0] = 1'b0;
      imem.instr_op = rop;
      imem.imem_ack = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      z = 1'($urandom);
      if (m_ph == PH_HALT || m_ph == PH_ERR) stuck++;
      else stuck = 0;
      reset = (stuck < 6);
      tick();
    end
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
